// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the AHB-to-APB bridge: transfer types, responses,
// FSM state codes and the APB slave address map.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_WWAIT  = 3'd1;
    localparam state_t ST_RSETUP = 3'd2;
    localparam state_t ST_WSETUP = 3'd3;
    localparam state_t ST_ACCESS = 3'd4;
    localparam state_t ST_ERR1   = 3'd5;
    localparam state_t ST_ERR2   = 3'd6;

    localparam logic [31:0] SLV0_BASE  = 32'h8000_0000;
    localparam logic [31:0] SLV0_LIMIT = 32'h83FF_FFFF;
    localparam logic [31:0] SLV1_BASE  = 32'h8400_0000;
    localparam logic [31:0] SLV1_LIMIT = 32'h87FF_FFFF;
    localparam logic [31:0] SLV2_BASE  = 32'h8800_0000;
    localparam logic [31:0] SLV2_LIMIT = 32'h8BFF_FFFF;

    localparam logic [2:0] HSIZE_MAX = 3'b010;
    localparam int TIMEOUT_DEFAULT = 16;

    // Only NONSEQ/SEQ beats with the bus ready start a transfer.
    function automatic logic is_valid(input logic hreadyin, input logic [1:0] htrans);
        return hreadyin && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    endfunction

endpackage

// File: rtl/ahb_apb_decoder.sv
// Address/size decoder: selects one APB slave or flags the transfer illegal.
module ahb_apb_decoder
    import ahb_apb_pkg::*;
(
    input  logic [31:0] haddr,
    input  logic [2:0]  hsize,
    output logic [2:0]  sel,
    output logic        illegal
);

    always_comb begin
        sel = 3'b000;
        if (haddr >= SLV0_BASE && haddr <= SLV0_LIMIT)
            sel = 3'b001;
        else if (haddr >= SLV1_BASE && haddr <= SLV1_LIMIT)
            sel = 3'b010;
        else if (haddr >= SLV2_BASE && haddr <= SLV2_LIMIT)
            sel = 3'b100;
        illegal = (sel == 3'b000) || (hsize > HSIZE_MAX);
    end

endmodule

// File: rtl/apb_bridge_fsm.sv
// AHB-to-APB bridge: one AHB beat becomes one APB setup/access pair, with
// an ACCESS wait-state timeout that turns into a two-cycle AHB ERROR.
module apb_bridge_fsm
    import ahb_apb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        hresetn,
    input  logic        hwrite,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic        hreadyin,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        pwrite,
    output logic [2:0]  psel,
    output logic        penable,
    input  logic [31:0] prdata,
    input  logic        pready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      addr_q;
    logic             write_q;
    logic [2:0]       sel_q;
    logic [2:0]       dec_sel;
    logic             dec_illegal;
    logic             valid;
    logic             unused_burst;

    // Bursts are broken into independent single beats, so hburst carries no information.
    assign unused_burst = ^hburst;
    assign valid = is_valid(hreadyin, htrans);

    ahb_apb_decoder u_decoder (
        .haddr   (haddr),
        .hsize   (hsize),
        .sel     (dec_sel),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            sel_q     <= 3'b000;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
            hrdata    <= '0;
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
            psel      <= 3'b000;
            penable   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    hreadyout <= 1'b1;
                    hresp     <= HRESP_OKAY;
                    if (valid) begin
                        addr_q    <= haddr;
                        write_q   <= hwrite;
                        sel_q     <= dec_sel;
                        hreadyout <= 1'b0;
                        if (dec_illegal) begin
                            hresp <= HRESP_ERROR;
                            state <= ST_ERR1;
                        end else if (hwrite) begin
                            state <= ST_WWAIT;
                        end else begin
                            paddr   <= haddr;
                            psel    <= dec_sel;
                            pwrite  <= 1'b0;
                            penable <= 1'b0;
                            state   <= ST_RSETUP;
                        end
                    end
                end
                // hwdata arrives in the AHB data phase, one cycle after the address.
                ST_WWAIT: begin
                    pwdata  <= hwdata;
                    paddr   <= addr_q;
                    psel    <= sel_q;
                    pwrite  <= 1'b1;
                    penable <= 1'b0;
                    state   <= ST_WSETUP;
                end
                ST_RSETUP, ST_WSETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        hreadyout <= 1'b1;
                        if (!write_q)
                            hrdata <= prdata;
                        psel    <= 3'b000;
                        penable <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (wait_cnt == CNT_LAST) begin
                        wait_cnt <= wait_cnt + 1'b1;
                        psel     <= 3'b000;
                        penable  <= 1'b0;
                        hresp    <= HRESP_ERROR;
                        state    <= ST_ERR1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_ERR1: begin
                    hresp     <= HRESP_ERROR;
                    hreadyout <= 1'b1;
                    state     <= ST_ERR2;
                end
                ST_ERR2: begin
                    hresp     <= HRESP_OKAY;
                    hreadyout <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    hresp     <= HRESP_OKAY;
                    hreadyout <= 1'b1;
                    psel      <= 3'b000;
                    penable   <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_bridge_fsm.sv
// Randomized bench for apb_bridge_fsm: each AHB beat is predicted at the
// transaction level (latency, response, APB fields, read data).
module tb_apb_bridge_fsm;

    logic        clk = 1'b0;
    logic        hresetn = 1'b0;
    logic        hwrite = 1'b0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hsize = 3'b000;
    logic [2:0]  hburst = 3'b000;
    logic        hreadyin = 1'b1;
    logic [31:0] haddr = '0;
    logic [31:0] hwdata = '0;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic [2:0]  psel;
    logic        penable;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] m_hrdata = '0;

    always #5 clk = ~clk;

    apb_bridge_fsm #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .hresetn   (hresetn),
        .hwrite    (hwrite),
        .htrans    (htrans),
        .hsize     (hsize),
        .hburst    (hburst),
        .hreadyin  (hreadyin),
        .haddr     (haddr),
        .hwdata    (hwdata),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pwrite    (pwrite),
        .psel      (psel),
        .penable   (penable),
        .prdata    (prdata),
        .pready    (pready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Address map as plain numbers: 64 MB windows starting at 0x8000_0000.
    function automatic logic [2:0] ref_sel(input logic [31:0] a);
        if (a < 32'h8000_0000)      return 3'b000;
        else if (a < 32'h8400_0000) return 3'b001;
        else if (a < 32'h8800_0000) return 3'b010;
        else if (a < 32'h8C00_0000) return 3'b100;
        else                        return 3'b000;
    endfunction

    // Entered and left at #1 after a rising edge with the bridge idle.
    task automatic run_xfer(input string name, input logic [1:0] trans, input logic rdyin,
                            input logic wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
        logic [2:0]  sel;
        logic        active, legal, tmo;
        int          exp_low, exp_err, exp_pen;
        logic [2:0]  exp_psel;
        int          low, err, pen, acc, cyc;
        logic [2:0]  psel_or;
        logic [31:0] paddr_s, pwdata_s;
        logic        pwrite_s, err_last_rdy, hung;

        sel     = ref_sel(addr);
        active  = rdyin && (trans == 2'b10 || trans == 2'b11);
        legal   = (sel != 3'b000) && (size <= 3'd2);
        tmo     = (delay >= 16);
        exp_low = !active ? 0 : !legal ? 1 :
                  (wr ? 2 : 1) + (tmo ? 16 : delay + 1) + (tmo ? 1 : 0);
        exp_err  = (active && (!legal || tmo)) ? 2 : 0;
        exp_pen  = (active && legal) ? (tmo ? 16 : delay + 1) : 0;
        exp_psel = (active && legal) ? sel : 3'b000;
        if (active && legal && !wr && !tmo)
            m_hrdata = rdata;

        htrans   = trans;
        hreadyin = rdyin;
        hwrite   = wr;
        haddr    = addr;
        hsize    = size;
        hburst   = 3'($urandom);
        hwdata   = $urandom;
        @(posedge clk); #1;
        htrans = 2'b00;
        hwdata = wdata;
        haddr  = $urandom;

        low = 0; err = 0; pen = 0; acc = 0; cyc = 0;
        psel_or = 3'b000; paddr_s = '0; pwdata_s = '0; pwrite_s = 1'b0;
        err_last_rdy = 1'b0; hung = 1'b0;
        while (!(hreadyout === 1'b1 && hresp === 2'b00)) begin
            if (cyc >= 60) begin
                hung = 1'b1;
                break;
            end
            if (hreadyout !== 1'b1) low++;
            if (hresp === 2'b01) begin
                err++;
                err_last_rdy = hreadyout;
            end
            if (psel !== 3'b000) begin
                psel_or  = psel_or | psel;
                paddr_s  = paddr;
                pwrite_s = pwrite;
                pwdata_s = pwdata;
            end
            if (penable === 1'b1) begin
                pen++;
                pready = (acc == delay);
                prdata = (acc == delay) ? rdata : $urandom;
                acc++;
            end else begin
                pready = 1'($urandom);
                prdata = $urandom;
            end
            cyc++;
            @(posedge clk); #1;
        end
        pready = 1'b0;

        check({name, ".bound"}, 32'(hung), 32'd0);
        check({name, ".low_cycles"}, 32'(low), 32'(exp_low));
        check({name, ".err_cycles"}, 32'(err), 32'(exp_err));
        check({name, ".penable_cycles"}, 32'(pen), 32'(exp_pen));
        check({name, ".psel"}, 32'(psel_or), 32'(exp_psel));
        if (exp_psel != 3'b000) begin
            check({name, ".paddr"}, paddr_s, addr);
            check({name, ".pwrite"}, 32'(pwrite_s), 32'(wr));
            if (wr) check({name, ".pwdata"}, pwdata_s, wdata);
        end
        if (exp_err != 0) check({name, ".err2_ready"}, 32'(err_last_rdy), 32'd1);
        check({name, ".hrdata"}, hrdata, m_hrdata);
    endtask

    task automatic check_reset_state(input string name);
        check({name, ".hreadyout"}, 32'(hreadyout), 32'd1);
        check({name, ".hresp"}, 32'(hresp), 32'd0);
        check({name, ".hrdata"}, hrdata, 32'd0);
        check({name, ".paddr"}, paddr, 32'd0);
        check({name, ".pwdata"}, pwdata, 32'd0);
        check({name, ".pwrite"}, 32'(pwrite), 32'd0);
        check({name, ".psel"}, 32'(psel), 32'd0);
        check({name, ".penable"}, 32'(penable), 32'd0);
    endtask

    initial begin
        logic [2:0]  r_size;
        logic [1:0]  r_trans;
        logic [31:0] r_addr;
        int          r_reg, r_delay, waited;

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        hresetn = 1'b1;

        run_xfer("rd_basic", 2'b10, 1'b1, 1'b0, 32'h8000_00A2, 3'b000, 32'h0, 32'h0000_FFFF, 0);
        run_xfer("wr_basic", 2'b10, 1'b1, 1'b1, 32'h8000_0001, 3'b000, 32'hA300_1111, 32'h0, 0);
        run_xfer("rd_wait3", 2'b11, 1'b1, 1'b0, 32'h8800_0010, 3'b010, 32'h0, 32'h1234_5678, 3);
        run_xfer("wr_wait2", 2'b10, 1'b1, 1'b1, 32'h8400_0020, 3'b001, 32'h5A5A_0F0F, 32'h0, 2);
        run_xfer("rd_tmo", 2'b10, 1'b1, 1'b0, 32'h8400_0004, 3'b010, 32'h0, 32'hDEAD_BEEF, 100);
        run_xfer("wr_tmo", 2'b10, 1'b1, 1'b1, 32'h8800_0008, 3'b010, 32'hCAFE_0001, 32'h0, 100);
        run_xfer("rd_illegal", 2'b10, 1'b1, 1'b0, 32'h9000_0000, 3'b000, 32'h0, 32'h1111_2222, 0);
        run_xfer("trans_idle", 2'b00, 1'b1, 1'b0, 32'h8000_0000, 3'b000, 32'h0, 32'h3333_4444, 0);
        run_xfer("trans_busy", 2'b01, 1'b1, 1'b1, 32'h8000_0000, 3'b000, 32'h77, 32'h0, 0);
        run_xfer("not_ready", 2'b10, 1'b0, 1'b0, 32'h8000_0000, 3'b000, 32'h0, 32'h5555_6666, 0);
        run_xfer("size_big", 2'b10, 1'b1, 1'b0, 32'h8000_0000, 3'b011, 32'h0, 32'h7777_8888, 0);
        run_xfer("edge_s0_top", 2'b10, 1'b1, 1'b0, 32'h83FF_FFFC, 3'b010, 32'h0, 32'h0BAD_F00D, 1);
        run_xfer("edge_s2_top", 2'b10, 1'b1, 1'b1, 32'h8BFF_FFFF, 3'b000, 32'h0000_00EE, 32'h0, 0);
        run_xfer("edge_above", 2'b10, 1'b1, 1'b0, 32'h8C00_0000, 3'b000, 32'h0, 32'h9999_AAAA, 0);
        run_xfer("edge_below", 2'b10, 1'b1, 1'b1, 32'h7FFF_FFFF, 3'b000, 32'h1, 32'h0, 0);

        // Reset while the slave stalls in ACCESS.
        htrans = 2'b10; hreadyin = 1'b1; hwrite = 1'b0; haddr = 32'h8400_0100; hsize = 3'b010;
        @(posedge clk); #1;
        htrans = 2'b00;
        pready = 1'b0;
        waited = 0;
        while (penable !== 1'b1 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        check("mid_reset.reached_access", 32'(penable), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        hresetn = 1'b0;
        #1;
        m_hrdata = '0;
        check_reset_state("mid_reset");
        @(posedge clk); #1;
        hresetn = 1'b1;
        run_xfer("post_reset_rd", 2'b10, 1'b1, 1'b0, 32'h8000_0040, 3'b010, 32'h0, 32'hFEED_0042, 0);

        for (int i = 0; i < 60; i++) begin
            r_reg = $urandom_range(0, 4);
            case (r_reg)
                0, 1, 2: r_addr = 32'h8000_0000 + 32'(r_reg) * 32'h0400_0000 + ($urandom & 32'h03FF_FFFF);
                3:       r_addr = $urandom;
                default: r_addr = 32'h8C00_0000 + ($urandom & 32'h0FFF_FFFF);
            endcase
            r_size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            r_delay = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 5);
            r_trans = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            run_xfer($sformatf("rnd%0d", i), r_trans, ($urandom_range(0, 7) != 0),
                     1'($urandom), r_addr, r_size, $urandom, $urandom, r_delay);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_bridge_fsm.md
APB_BRIDGE_FSM -- requirements
Module: apb_bridge_fsm

Interface
REQ-001 SHALL have port clk, input, 1: the single bridge clock; all state updates on its rising edge.
REQ-002 SHALL have port hresetn, input, 1: asynchronous reset, active-low.
REQ-003 SHALL have AHB inputs: hwrite 1, htrans 2, hsize 3, hburst 3, hreadyin 1, haddr 32, hwdata 32.
REQ-004 SHALL have AHB outputs: hreadyout 1 (transfer complete), hresp 2 (00 OKAY, 01 ERROR), hrdata 32 (read data).
REQ-005 SHALL have APB outputs: paddr 32, pwdata 32, pwrite 1, psel 3 (one-hot slave select), penable 1.
REQ-006 SHALL have APB inputs: prdata 32 (read data) and pready 1 (access complete).
REQ-007 SHALL have parameter TIMEOUT, default 16: maximum ACCESS cycles with pready low.

Function
REQ-008 Valid transfer SHALL be defined as: hreadyin=1, htrans in {NONSEQ 10, SEQ 11}, sampled in IDLE. IDLE 00 and BUSY 01 SHALL cause no action and an OKAY response.
REQ-009 Decode: 0x8000_0000-0x83FF_FFFF -> psel=001; 0x8400_0000-0x87FF_FFFF -> 010; 0x8800_0000-0x8BFF_FFFF -> 100; other addresses, or hsize>010, SHALL be illegal.
REQ-010 States SHALL be IDLE, WWAIT, RSETUP, WSETUP, ACCESS, ERR1, ERR2.
REQ-011 In IDLE, hreadyout=1 and psel=000; a valid legal transfer SHALL latch haddr and hwrite and set hreadyout=0 on the same edge.
REQ-012 Read path: IDLE -> RSETUP (paddr, psel, pwrite=0 driven, penable=0) -> ACCESS (penable=1).
REQ-013 Write path: IDLE -> WWAIT (hwdata sampled at end of cycle) -> WSETUP (pwdata, paddr, psel, pwrite=1, penable=0) -> ACCESS.
REQ-014 ACCESS with pready=1: hreadyout<=1; hrdata<=prdata on reads; psel<=000; penable<=0; next state IDLE.
REQ-015 Read latency: hreadyout SHALL return high 3 cycles after acceptance when pready=1. Write latency: 4 cycles.
REQ-016 ACCESS with pready=0 SHALL hold all APB outputs stable and increment the wait counter.
REQ-017 When the counter reaches TIMEOUT, the bridge SHALL drop psel and penable and enter ERR1.
REQ-018 An illegal valid transfer in IDLE SHALL go to ERR1 and generate no APB activity.
REQ-019 ERR1 SHALL drive hresp=01, hreadyout=0; ERR2 SHALL drive hresp=01, hreadyout=1; ERR2 -> IDLE.
REQ-020 hresp SHALL be 00 in all other states.
REQ-021 hrdata SHALL hold its last value until the next completed read; writes SHALL NOT alter it.
REQ-022 The wait counter SHALL clear on every entry to ACCESS.
REQ-023 hburst SHALL be ignored; each beat is handled as an independent single transfer.

Reset
REQ-024 hresetn low SHALL immediately force state=IDLE, hreadyout=1, hresp=00, hrdata=0, paddr=0, pwdata=0, pwrite=0, psel=000, penable=0, and counter=0, including mid-ACCESS.
REQ-025 After hresetn deasserts, the first valid transfer SHALL be acceptable on the first rising edge.

Structure
REQ-026 Package ahb_apb_pkg SHALL hold: htrans encodings, the hresp encodings, the state enum, slave base/limit address constants, and TIMEOUT default.
REQ-027 Combinational sub-module ahb_apb_decoder SHALL map haddr and hsize to psel and an illegal flag.

Verification
REQ-028 Single read, haddr=0x8000_00A2, hsize=000, prdata=0x0000_FFFF, pready=1 -> psel=001, penable high 1 cycle, hrdata=0x0000_FFFF, hreadyout high 3 cycles after acceptance.
REQ-029 Single write, haddr=0x8000_0001, hwdata=0xA300_1111 -> pwdata=0xA300_1111, pwrite=1, psel=001, hreadyout high 4 cycles after acceptance.
REQ-030 Read to 0x8800_0010 with pready low for 3 cycles -> penable held 4 cycles, hresp=00, psel=100.
REQ-031 Access with pready stuck low -> abort after 16 ACCESS cycles; ERR1/ERR2 two-cycle 01 response.
REQ-032 Read to 0x9000_0000 -> no psel activity; hresp=01 for 2 cycles, with hreadyout 0 then 1.
REQ-033 hresetn pulsed low during ACCESS -> psel=000, penable=0, hreadyout=1 immediately; next read completes normally.
